// File: rtl/morse_tx.sv
// Morse transmitter: takes one encoded character per valid/ready handshake
// and keys key_out with standard dot/dash/gap timing measured in clk50 cycles.
module morse_tx #(
  parameter int UNIT_CYCLES = 12_500_000
) (
  input  logic       clk50,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_len,
  input  logic [4:0] in_code,
  output logic       key_out,
  output logic       busy,
  output logic       char_done
);

  // Cycle counter width; a one-cycle unit still needs a 1-bit counter.
  localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MARK, GAP, TAIL} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cyc_reg, cyc_next;
  logic [1:0]      unit_reg, unit_next;
  logic [1:0]      last_unit_reg, last_unit_next;  // units in this state, minus one
  logic [2:0]      idx_reg, idx_next;
  logic [2:0]      len_reg, len_next;
  logic [4:0]      code_reg, code_next;
  logic            key_out_reg, in_ready_reg, busy_reg, char_done_reg;
  logic            accept, state_end;

  // Last unit index of a mark: dash lasts 3 units, dot lasts 1.
  function automatic logic [1:0] mark_last(input logic [4:0] code, input logic [2:0] idx);
    logic is_dash;
    case (idx)
      3'd0:    is_dash = code[0];
      3'd1:    is_dash = code[1];
      3'd2:    is_dash = code[2];
      3'd3:    is_dash = code[3];
      3'd4:    is_dash = code[4];
      default: is_dash = 1'b0;
    endcase
    return is_dash ? 2'd2 : 2'd0;
  endfunction

  // Next-state, counter and latched-character logic.
  always_comb begin
    state_next     = state_reg;
    cyc_next       = cyc_reg;
    unit_next      = unit_reg;
    last_unit_next = last_unit_reg;
    idx_next       = idx_reg;
    len_next       = len_reg;
    code_next      = code_reg;

    accept    = in_valid && in_ready_reg;
    state_end = (cyc_reg == CYC_LAST) && (unit_reg == last_unit_reg);

    case (state_reg)
      IDLE: begin
        cyc_next  = '0;
        unit_next = 2'd0;
        if (accept) begin
          code_next = in_code;
          len_next  = (in_len > 3'd5) ? 3'd5 : in_len;
          idx_next  = 3'd0;
          if (in_len == 3'd0) begin
            state_next     = TAIL;
            last_unit_next = 2'd3;
          end else begin
            state_next     = MARK;
            last_unit_next = mark_last(in_code, 3'd0);
          end
        end
      end
      default: begin
        if (cyc_reg == CYC_LAST) begin
          cyc_next  = '0;
          unit_next = unit_reg + 2'd1;
        end else begin
          cyc_next = cyc_reg + CW'(1);
        end
        // Every state entry restarts both counters so durations are exact.
        if (state_end) begin
          cyc_next  = '0;
          unit_next = 2'd0;
          case (state_reg)
            MARK: begin
              if (idx_reg == 3'(len_reg - 3'd1)) begin
                state_next     = TAIL;
                last_unit_next = 2'd2;
              end else begin
                state_next     = GAP;
                last_unit_next = 2'd0;
              end
            end
            GAP: begin
              idx_next       = 3'(idx_reg + 3'd1);
              state_next     = MARK;
              last_unit_next = mark_last(code_reg, 3'(idx_reg + 3'd1));
            end
            default: state_next = IDLE;
          endcase
        end
      end
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cyc_reg       <= '0;
      unit_reg      <= 2'd0;
      last_unit_reg <= 2'd0;
      idx_reg       <= 3'd0;
      len_reg       <= 3'd0;
      code_reg      <= 5'd0;
      key_out_reg   <= 1'b0;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
      char_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cyc_reg       <= cyc_next;
      unit_reg      <= unit_next;
      last_unit_reg <= last_unit_next;
      idx_reg       <= idx_next;
      len_reg       <= len_next;
      code_reg      <= code_next;
      key_out_reg   <= (state_next == MARK);
      in_ready_reg  <= (state_next == IDLE);
      busy_reg      <= (state_next != IDLE);
      char_done_reg <= (state_next == TAIL) && (cyc_next == CYC_LAST) &&
                       (unit_next == last_unit_next);
    end
  end

  assign key_out   = key_out_reg;
  assign in_ready  = in_ready_reg;
  assign busy      = busy_reg;
  assign char_done = char_done_reg;

endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx with UNIT_CYCLES=4; every cycle of each
// character is compared against hand-derived key/done/ready/busy values.
module tb_morse_tx;
  localparam int U = 4;

  logic       clk50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_len = 3'd0;
  logic [4:0] in_code = 5'd0;
  logic       in_ready, key_out, busy, char_done;

  int n_assert = 0;
  int n_fail   = 0;

  morse_tx #(.UNIT_CYCLES(U)) dut (
    .clk50(clk50), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_len(in_len), .in_code(in_code), .key_out(key_out), .busy(busy),
    .char_done(char_done)
  );

  always #5 clk50 = ~clk50;

  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  // Present a character and return in cycle 1 (just after the accept edge).
  task automatic send(input logic [2:0] l, input logic [4:0] c);
    int t;
    in_len = l; in_code = c; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 200) begin step(); t++; end
    n_assert++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: in_ready=%b required 1 within 200 cycles", in_ready);
    end
    step();
    in_valid = 1'b0;
    $display("sent len=%0d code=%b", l, c);
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    rst_n = 1'b0;
    repeat (3) step();
    obs = {key_out, char_done, in_ready, busy};
    n_assert++;
    if (obs !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_hold: key/done/ready/busy=%b required 0010", obs);
    end
    rst_n = 1'b1;
    step();
    obs = {key_out, char_done, in_ready, busy};
    n_assert++;
    if (obs !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_release: key/done/ready/busy=%b required 0010", obs);
    end
    $display("reset checked");
  endtask

  task automatic test_e();
    logic [3:0] obs, exp;
    send(3'd1, 5'b00000);
    for (int k = 1; k <= 17; k++) begin
      exp = {(k <= 4), (k == 16), (k == 17), (k != 17)};
      obs = {key_out, char_done, in_ready, busy};
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL e_cycle%0d: key/done/ready/busy=%b required %b", k, obs, exp);
      end
      if (k < 17) step();
    end
  endtask

  task automatic test_a();
    logic [3:0] obs, exp;
    send(3'd2, 5'b00010);
    for (int k = 1; k <= 33; k++) begin
      exp = {(k <= 4) || (k >= 9 && k <= 20), (k == 32), (k == 33), (k != 33)};
      obs = {key_out, char_done, in_ready, busy};
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL a_cycle%0d: key/done/ready/busy=%b required %b", k, obs, exp);
      end
      if (k < 33) step();
    end
  endtask

  // Five dashes: marks of 12 cycles on a 16-cycle pitch, tail to cycle 88.
  task automatic test_zero(input logic [2:0] l);
    logic [3:0] obs, exp;
    send(l, 5'b11111);
    for (int k = 1; k <= 89; k++) begin
      exp = {(k <= 76) && (((k - 1) % 16) < 12), (k == 88), (k == 89), (k != 89)};
      obs = {key_out, char_done, in_ready, busy};
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL zero_len%0d_cycle%0d: key/done/ready/busy=%b required %b", l, k, obs, exp);
      end
      if (k < 89) step();
    end
  endtask

  task automatic test_space();
    logic [3:0] obs, exp;
    send(3'd0, 5'b10101);
    for (int k = 1; k <= 17; k++) begin
      exp = {1'b0, (k == 16), (k == 17), (k != 17)};
      obs = {key_out, char_done, in_ready, busy};
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL space_cycle%0d: key/done/ready/busy=%b required %b", k, obs, exp);
      end
      if (k < 17) step();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs, exp;
    send(3'd1, 5'b00000);
    // Source immediately offers 'T' and keeps in_valid high.
    in_len = 3'd1; in_code = 5'b00001; in_valid = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      exp = {(k <= 4), (k == 16), (k == 17), (k != 17)};
      obs = {key_out, char_done, in_ready, busy};
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL b2b_e_cycle%0d: key/done/ready/busy=%b required %b", k, obs, exp);
      end
      if (k < 17) step();
    end
    step();  // edge ending cycle 17 accepts 'T'
    $display("sent len=1 code=00001 (back-to-back)");
    for (int k = 1; k <= 25; k++) begin
      if (k == 3) begin in_code = 5'b00000; in_len = 3'd2; end
      if (k == 24) in_valid = 1'b0;
      exp = {(k <= 12), (k == 24), (k == 25), (k != 25)};
      obs = {key_out, char_done, in_ready, busy};
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL b2b_t_cycle%0d: key/done/ready/busy=%b required %b", k, obs, exp);
      end
      if (k < 25) step();
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] obs, exp;
    logic       seen_done;
    send(3'd1, 5'b00001);
    for (int k = 1; k <= 6; k++) begin
      exp = 4'b1001;
      obs = {key_out, char_done, in_ready, busy};
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rstmid_cycle%0d: key/done/ready/busy=%b required %b", k, obs, exp);
      end
      if (k < 6) step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    obs = {key_out, char_done, in_ready, busy};
    n_assert++;
    if (obs !== 4'b0010) begin
      n_fail++;
      $display("FAIL rstmid_cycle7: key/done/ready/busy=%b required 0010", obs);
    end
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (char_done === 1'b1) seen_done = 1'b1;
      step();
    end
    n_assert++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_no_done: char_done seen=%b required 0", seen_done);
    end
    $display("mid-character reset checked");
    test_zero(3'd7);
  endtask

  initial begin
    test_reset();
    test_e();
    test_a();
    test_zero(3'd5);
    test_space();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_tx.md
# morse_tx

Morse transmitter: the transmit end of the board's Morse link. It accepts one encoded character per valid/ready handshake and drives a keyed on/off signal with standard dot/dash timing, which the top level routes to an LED. Its output timing matches what the key-press receiver measures: run lengths of a held signal, counted in `clk50` cycles.

## Interface
- `UNIT_CYCLES`, default 12_500_000: `clk50` cycles per Morse time unit (250 ms at 50 MHz). Must be ≥ 1.
- `clk50`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  a character is present on `in_len`/`in_code`.
- `in_ready`  out  1  block is idle and accepts a character this cycle.
- `in_len`  in  3  element count, 1..5. 0 = word space. 6 and 7 are treated as 5.
- `in_code`  in  5  elements; bit0 is sent first. 1 = dash, 0 = dot. Bits at index ≥ effective length are ignored.
- `key_out`  out  1  keyed signal, 1 = mark (tone or LED on).
- `busy`  out  1  a character or space is in progress (equals !`in_ready`).
- `char_done`  out  1  single-cycle pulse on the last cycle of a character's trailing gap.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - MARK: `key_out`=1.
  - GAP: 1-unit inter-element silence.
  - TAIL: trailing silence.
- Accept: `in_valid` && `in_ready` at a rising edge. `in_len` and `in_code` are latched at that edge and are not sampled again.
- From IDLE on accept:
  - Effective length ≥ 1: go to MARK for element 0.
  - Length 0: go to TAIL with 4 units.
- MARK lasts 1 unit (dot) or 3 units (dash). Then:
  - More elements remain: go to GAP (1 unit), then MARK for the next element.
  - Last element: go to TAIL with 3 units.
- TAIL counts down its units. On its final cycle `char_done`=1; next state is IDLE.
- Word spacing: a character's 3-unit tail plus a following space's 4 units gives the standard 7 units.
- Timing is kept by a cycle counter, 0..`UNIT_CYCLES`-1, and a unit counter, 0..3. Both restart at every state entry, so each state lasts exactly N×`UNIT_CYCLES` cycles with no prescaler phase error.
- Element index: 0..4, 3 bits. The element type is `code_reg[idx]`.
- Reset, including mid-character: the next state is IDLE and the current character is discarded with no `char_done`. Reset values: `key_out`=0, `busy`=0, `char_done`=0, `in_ready`=1.
- `in_valid` asserted while busy has no effect. The source must hold the character until it is accepted.
- With `UNIT_CYCLES`=1, every unit is exactly one cycle and all behaviour above still holds.

## Timing
- All outputs are registered.
- Cycle numbering: the accept edge is cycle 0. Cycle k is the state after the k-th subsequent edge.
- `key_out` rises in cycle 1. `busy` goes to 1 and `in_ready` to 0 in cycle 1.
- Total duration in units, D = Σ(mark units) + (len−1) + 3 for a character, or 4 for a space.
- `char_done`=1 in cycle D×U, where U = `UNIT_CYCLES`. In cycle D×U+1: `in_ready`=1, `busy`=0.
- Back-to-back throughput: with `in_valid` held, the next accept edge ends cycle D×U+1. There are no extra idle cycles beyond that one.

## Test plan
All scenarios use `UNIT_CYCLES`=4.
- 'E' (len 1, code 00000):
  - `key_out`=1 in cycles 1–4 and 0 in cycles 5–16.
  - `char_done` in cycle 16 only; `in_ready`=1 in cycle 17.
- 'A' (len 2, code 00010):
  - `key_out` high 1–4, low 5–8, high 9–20, low 21–32.
  - `char_done` in cycle 32.
- '0' (len 5, code 11111): five 12-cycle marks separated by 4-cycle gaps, the last mark ending in cycle 76. `char_done` in cycle 88.
- Word space (len 0): `key_out`=0 throughout; `char_done` in cycle 16; `in_ready` in cycle 17.
- Back-to-back 'E' then 'T', `in_valid` held:
  - Second accept at the edge ending cycle 17.
  - `key_out` high relative cycles 1–12, `char_done` in relative cycle 24.
  - `in_code` changes while busy do not alter the output.
- Reset and length clamping:
  - Accept 'T' (len 1, code 00001). Drive `rst_n`=0 during cycle 6.
  - Required: cycle 7 has `key_out`=0, `in_ready`=1, and no `char_done` ever appears.
  - Then send len 7, code 11111: timing must be identical to the '0' scenario.
